// File: rtl/capture_mem_ctrl_pkg.sv
// Shared definitions for the sample-capture SRAM controller: size defaults and FSM/status encoding.
// The State encoding below is decoded by the MCU status register, so its values are fixed.
package capture_mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 8;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/capture_mem_ctrl_circ_addr_counter.sv
// Circular SRAM address pointer: synchronous clear > load > increment, wraps 2**ADDR_W-1 -> 0.
// One-cycle update latency; never stalls.
module circ_addr_counter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/capture_mem_ctrl.sv
// Circular-buffer capture of two-channel ADC samples into SRAM, trigger latch, then MCU readback.
// One clock sample-to-strobe; no backpressure: every CLK_EN sample is written, pointer advances after the strobe.
module capture_mem_ctrl
  import capture_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic                CLK_EN,
  input  logic                Start_Write,
  input  logic                Write_Ready,
  input  logic                sync_state,
  input  logic [DATA_W-1:0]   DATA_IN_A,
  input  logic [DATA_W-1:0]   DATA_IN_B,
  input  logic                Read_Start,
  input  logic                Read_Next,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic [2*DATA_W-1:0] SRAM_DQ_OUT,
  output logic                SRAM_WE_n,
  output logic                SRAM_OE_n,
  output logic [ADDR_W-1:0]   Trig_Addr,
  output logic                Trig_Valid,
  output logic                Capture_Done,
  output logic [1:0]          State
);

  state_t              state_q, state_d;
  logic                we_n_q, oe_n_q;
  logic [2*DATA_W-1:0] dq_q;
  logic [ADDR_W-1:0]   trig_addr_q, last_addr_q;
  logic                trig_valid_q;
  logic [ADDR_W-1:0]   addr, wr_ptr;
  logic                wr_en, cnt_clr, cnt_load, cnt_inc, trig_set, last_set;

  // The pointer only moves after a strobe, so while one is in flight the next sample lands one slot ahead.
  assign wr_ptr = we_n_q ? addr : addr + ADDR_W'(1);

  circ_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk      (CLK),
    .rst_n    (RESET_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (last_addr_q + ADDR_W'(1)),
    .inc      (cnt_inc),
    .cnt      (addr)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = !we_n_q;
    trig_set = 1'b0;
    last_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_Write) begin
          state_d = ST_WRITE;
          cnt_clr = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!Start_Write) begin
          state_d = ST_IDLE;
        end else begin
          trig_set = sync_state && !trig_valid_q;
          if (Write_Ready) begin
            state_d  = ST_DONE;
            last_set = 1'b1;
          end else begin
            wr_en = CLK_EN;
          end
        end
      end
      ST_DONE, ST_READ: begin
        if (!Start_Write) begin
          state_d = ST_IDLE;
        end else if (Read_Start) begin
          state_d  = ST_READ;
          cnt_load = 1'b1;
        end else if (state_q == ST_READ && Read_Next) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_q         <= '0;
      trig_addr_q  <= '0;
      trig_valid_q <= 1'b0;
      last_addr_q  <= '0;
    end else begin
      we_n_q <= !wr_en;
      oe_n_q <= (state_d != ST_READ);
      if (wr_en) dq_q <= {DATA_IN_B, DATA_IN_A};
      if (cnt_clr) begin
        trig_valid_q <= 1'b0;
      end else if (trig_set) begin
        trig_valid_q <= 1'b1;
        trig_addr_q  <= wr_ptr;
      end
      if (last_set) last_addr_q <= wr_ptr - ADDR_W'(1);
    end
  end

  assign SRAM_ADDR    = addr;
  assign SRAM_DQ_OUT  = dq_q;
  assign SRAM_WE_n    = we_n_q;
  assign SRAM_OE_n    = oe_n_q;
  assign Trig_Addr    = trig_addr_q;
  assign Trig_Valid   = trig_valid_q;
  assign Capture_Done = (state_q == ST_DONE) || (state_q == ST_READ);
  assign State        = state_q;

endmodule

// File: tb/tb_capture_mem_ctrl.sv
// Directed + randomized bench for capture_mem_ctrl against a sample-count reference model.
module tb_capture_mem_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int P_IDLE = 0, P_WRITE = 1, P_DONE = 2, P_READ = 3;

  logic          CLK = 1'b0;
  logic          RESET_n, CLK_EN, Start_Write, Write_Ready, sync_state;
  logic [DW-1:0] DATA_IN_A, DATA_IN_B;
  logic          Read_Start, Read_Next;
  logic [AW-1:0] SRAM_ADDR;
  logic [2*DW-1:0] SRAM_DQ_OUT;
  logic          SRAM_WE_n, SRAM_OE_n;
  logic [AW-1:0] Trig_Addr;
  logic          Trig_Valid, Capture_Done;
  logic [1:0]    State;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase, samples accepted this capture, trigger, last written slot, read pointer.
  int phase, cnt, tv, ta, last, rd, strobes;
  logic            exp_strobe;
  int              exp_waddr;
  logic [2*DW-1:0] exp_wdat;

  always #5 CLK = ~CLK;

  capture_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK          (CLK),
    .RESET_n      (RESET_n),
    .CLK_EN       (CLK_EN),
    .Start_Write  (Start_Write),
    .Write_Ready  (Write_Ready),
    .sync_state   (sync_state),
    .DATA_IN_A    (DATA_IN_A),
    .DATA_IN_B    (DATA_IN_B),
    .Read_Start   (Read_Start),
    .Read_Next    (Read_Next),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_DQ_OUT  (SRAM_DQ_OUT),
    .SRAM_WE_n    (SRAM_WE_n),
    .SRAM_OE_n    (SRAM_OE_n),
    .Trig_Addr    (Trig_Addr),
    .Trig_Valid   (Trig_Valid),
    .Capture_Done (Capture_Done),
    .State        (State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst_n_i, input logic sw, input logic en, input logic wr,
                       input logic ss, input logic rs, input logic rn);
    logic [DW-1:0] a, b;
    a = DW'($urandom);
    b = DW'($urandom);
    RESET_n = rst_n_i; Start_Write = sw; CLK_EN = en; Write_Ready = wr;
    sync_state = ss; Read_Start = rs; Read_Next = rn;
    DATA_IN_A = a; DATA_IN_B = b;
    @(posedge CLK);
    exp_strobe = 1'b0;
    if (!rst_n_i) begin
      phase = P_IDLE; cnt = 0; tv = 0; ta = 0; last = 0;
    end else begin
      case (phase)
        P_IDLE: if (sw) begin phase = P_WRITE; cnt = 0; tv = 0; end
        P_WRITE: begin
          if (!sw) begin
            phase = P_IDLE;
          end else begin
            if (ss && tv == 0) begin tv = 1; ta = cnt % DEPTH; end
            if (wr) begin
              last  = (cnt + DEPTH - 1) % DEPTH;
              phase = P_DONE;
            end else if (en) begin
              exp_strobe = 1'b1;
              exp_waddr  = cnt % DEPTH;
              exp_wdat   = {b, a};
              cnt++;
            end
          end
        end
        default: begin
          if (!sw) phase = P_IDLE;
          else if (rs) begin phase = P_READ; rd = (last + 1) % DEPTH; end
          else if (phase == P_READ && rn) rd = (rd + 1) % DEPTH;
        end
      endcase
    end
    #1;
    chk("state", 32'(State), phase);
    chk("capture_done", 32'(Capture_Done), (phase == P_DONE || phase == P_READ) ? 1 : 0);
    chk("we_n", 32'(SRAM_WE_n), exp_strobe ? 0 : 1);
    chk("oe_n", 32'(SRAM_OE_n), (phase == P_READ) ? 0 : 1);
    chk("trig_valid", 32'(Trig_Valid), tv);
    if (tv != 0 || !rst_n_i) chk("trig_addr", 32'(Trig_Addr), ta);
    if (exp_strobe) begin
      chk("wr_addr", 32'(SRAM_ADDR), exp_waddr);
      chk("wr_data", 32'(SRAM_DQ_OUT), 32'(exp_wdat));
    end
    if (phase == P_READ) chk("rd_addr", 32'(SRAM_ADDR), rd);
    if (!rst_n_i) begin
      chk("rst_addr", 32'(SRAM_ADDR), 0);
      chk("rst_dq", 32'(SRAM_DQ_OUT), 0);
    end
    if (SRAM_WE_n === 1'b0) strobes++;
  endtask

  initial begin
    phase = P_IDLE; cnt = 0; tv = 0; ta = 0; last = 0; rd = 0; strobes = 0;
    exp_waddr = 0; exp_wdat = '0;

    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 1, 1);

    // Continuous capture with wrap; trigger on the 7th sample, later pulse ignored.
    cycle(1, 1, 0, 0, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 20; i++) cycle(1, 1, 1, 0, (i >= 6 && i < 9) || i == 14, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    chk("strobe_count", 32'(strobes), 20);
    chk("trig_addr_s2", 32'(Trig_Addr), 6);
    chk("state_done", 32'(State), 2);

    // Readback from oldest sample.
    cycle(1, 1, 0, 0, 0, 1, 0);
    chk("rd_oldest", 32'(SRAM_ADDR), 4);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 1);
    chk("rd_after3", 32'(SRAM_ADDR), 7);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 1);

    // Sparse CLK_EN; Write_Ready lands on an enabled cycle.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, 1, (i % 3) == 2, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0);
    chk("sparse_oldest", 32'(SRAM_ADDR), 4);

    // Abort mid-write after address 9, then re-arm.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, i == 3, 0, 0);
    cycle(1, 0, 1, 1, 0, 1, 1);
    chk("abort_state", 32'(State), 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("rearm_tv", 32'(Trig_Valid), 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    chk("rearm_addr", 32'(SRAM_ADDR), 0);

    // Reset during readback; later Read_Next ignored.
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, i == 2, 0, 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    chk("post_rst_addr", 32'(SRAM_ADDR), 0);
    chk("post_rst_oe", 32'(SRAM_OE_n), 1);

    // Randomized captures, reads and aborts.
    for (int k = 0; k < 10; k++) begin
      int len;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0);
      len = $urandom_range(3, 40);
      for (int i = 0; i < len; i++) begin
        logic sw_r;
        sw_r = !(k == 6 && i == len - 1);
        cycle(1, sw_r, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cycle(1, 1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0, 0);
      for (int j = 0; j < 12; j++)
        cycle(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
              $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
